// File: rtl/exec_issue_queue.sv
// exec_issue_queue: circular issue queue between decode and the execute stage.
// Entries are popped when the exec stage accepts the head. Entries whose
// context is squashed by a branch kill are dropped without being offered.
// Optional statistics counters are built when ISSUE_QUEUE_STATS_EN is defined.
module exec_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int LEN_CTX = 2,
    parameter int LEN_PA  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_exec_type,
    input  logic               in_io_type,
    input  logic [2:0]         in_func3,
    input  logic [6:0]         in_func7,
    input  logic [LEN_PA-1:0]  in_pa_rd,
    input  logic [31:0]        in_d_rs1,
    input  logic [31:0]        in_d_rs2,
    input  logic [LEN_CTX-1:0] in_context,
    input  logic [LEN_CTX-1:0] in_b_t_context,
    input  logic [LEN_CTX-1:0] in_b_f_context,
    output logic               order,
    input  logic               accepted,
    input  logic               done,
    output logic [7:0]         exec_type,
    output logic               io_type,
    output logic [2:0]         func3,
    output logic [6:0]         func7,
    output logic [LEN_PA-1:0]  pa_rd,
    output logic [31:0]        d_rs1,
    output logic [31:0]        d_rs2,
    output logic [LEN_CTX-1:0] context_tag,  // "context" is a reserved word
    output logic [LEN_CTX-1:0] b_t_context,
    output logic [LEN_CTX-1:0] b_f_context,
    input  logic               kill,
    input  logic [LEN_CTX-1:0] kill_context,
    output logic [31:0]        cnt_issued,
    output logic [31:0]        cnt_killed
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [7:0]         exec_type;
        logic               io_type;
        logic [2:0]         func3;
        logic [6:0]         func7;
        logic [LEN_PA-1:0]  pa_rd;
        logic [31:0]        d_rs1;
        logic [31:0]        d_rs2;
        logic [LEN_CTX-1:0] ctx;
        logic [LEN_CTX-1:0] b_t_ctx;
        logic [LEN_CTX-1:0] b_f_ctx;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    entry_t             mem [DEPTH];
    logic [DEPTH-1:0]   killed;
    logic [DEPTH-1:0]   kill_hit;
    logic [PTR_W-1:0]   head, tail, head_next, offset;
    logic [PTR_W:0]     count;
    state_t             state, state_nxt;
    logic               push_any, push_drop, push, pop, drop, rm;
    logic               head_valid, head_killed, next_valid, next_killed;

    assign in_ready    = (count < COUNT_FULL);
    assign push_any    = in_valid & in_ready;
    assign push_drop   = push_any & kill & (in_context == kill_context);
    assign push        = push_any & ~push_drop;
    assign head_next   = head + 1'b1;
    assign head_valid  = (count != '0);
    assign head_killed = killed[head];
    assign next_valid  = (count > (PTR_W + 1)'(1));
    assign next_killed = killed[head_next];
    assign rm          = pop | drop;

    assign exec_type   = mem[head].exec_type;
    assign io_type     = mem[head].io_type;
    assign func3       = mem[head].func3;
    assign func7       = mem[head].func7;
    assign pa_rd       = mem[head].pa_rd;
    assign d_rs1       = mem[head].d_rs1;
    assign d_rs2       = mem[head].d_rs2;
    assign context_tag = mem[head].ctx;
    assign b_t_context = mem[head].b_t_ctx;
    assign b_f_context = mem[head].b_f_ctx;

    // Mark occupied entries whose context matches the kill strobe.
    always_comb begin
        kill_hit = '0;
        offset   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - head;
            if (kill && ({1'b0, offset} < count) && (mem[i].ctx == kill_context))
                kill_hit[i] = 1'b1;
        end
    end

    // Next-state logic: offer, pop on accept, drop killed heads.
    always_comb begin
        state_nxt = state;
        order     = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (head_valid) begin
                    if (head_killed) drop = 1'b1;
                    else             state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!head_valid) begin
                    state_nxt = IDLE;
                end else if (head_killed) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    order = 1'b1;
                    if (accepted) begin
                        pop = 1'b1;
                        if (done) state_nxt = (next_valid && !next_killed) ? ISSUE : IDLE;
                        else      state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (done) state_nxt = (head_valid && !head_killed) ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (push) tail <= tail + 1'b1;
            if (rm)   head <= head_next;
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(rm);
        end
    end

    // Per-entry kill flags: cleared on write, set by a matching kill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            killed <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push && (tail == PTR_W'(i))) killed[i] <= 1'b0;
                else if (kill_hit[i])            killed[i] <= 1'b1;
            end
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= '{in_exec_type, in_io_type, in_func3, in_func7, in_pa_rd,
                           in_d_rs1, in_d_rs2, in_context, in_b_t_context, in_b_f_context};
    end

`ifdef ISSUE_QUEUE_STATS_EN
    // Statistics: issued on accept, killed on head drop or discarded push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_issued <= '0;
            cnt_killed <= '0;
        end else begin
            cnt_issued <= cnt_issued + 32'(pop);
            cnt_killed <= cnt_killed + 32'(drop) + 32'(push_drop);
        end
    end
`else
    assign cnt_issued = '0;
    assign cnt_killed = '0;
`endif

endmodule

// File: tb/tb_exec_issue_queue.sv
// Directed self-checking bench for exec_issue_queue (DEPTH=4).
module tb_exec_issue_queue;

    logic        clk, rst;
    logic        in_valid, in_ready, in_io_type;
    logic [7:0]  in_exec_type;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [5:0]  in_pa_rd;
    logic [31:0] in_d_rs1, in_d_rs2;
    logic [1:0]  in_context, in_b_t_context, in_b_f_context;
    logic        order, accepted, done, io_type, kill;
    logic [7:0]  exec_type;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [5:0]  pa_rd;
    logic [31:0] d_rs1, d_rs2, cnt_issued, cnt_killed;
    logic [1:0]  context_tag, b_t_context, b_f_context, kill_context;

    int errors = 0;
    int checks = 0;
    int issued_exp = 0;
    int killed_exp = 0;

`ifdef ISSUE_QUEUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    exec_issue_queue #(.DEPTH(4), .LEN_CTX(2), .LEN_PA(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exec_type(in_exec_type), .in_io_type(in_io_type),
        .in_func3(in_func3), .in_func7(in_func7), .in_pa_rd(in_pa_rd),
        .in_d_rs1(in_d_rs1), .in_d_rs2(in_d_rs2),
        .in_context(in_context), .in_b_t_context(in_b_t_context),
        .in_b_f_context(in_b_f_context),
        .order(order), .accepted(accepted), .done(done),
        .exec_type(exec_type), .io_type(io_type), .func3(func3), .func7(func7),
        .pa_rd(pa_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .context_tag(context_tag),
        .b_t_context(b_t_context), .b_f_context(b_f_context),
        .kill(kill), .kill_context(kill_context),
        .cnt_issued(cnt_issued), .cnt_killed(cnt_killed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] exp_cnt(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 0; in_exec_type = 8'h01; in_io_type = 0; in_func3 = 0; in_func7 = 0;
        in_pa_rd = 0; in_d_rs1 = 0; in_d_rs2 = 0; in_context = 0;
        in_b_t_context = 0; in_b_f_context = 0;
        accepted = 0; done = 0; kill = 0; kill_context = 0;
    endtask

    task automatic drive_push(input logic [31:0] d, input logic [1:0] ctx);
        in_valid = 1; in_d_rs1 = d; in_d_rs2 = ~d; in_pa_rd = d[5:0]; in_context = ctx;
        tick;
        in_valid = 0;
    endtask

    task automatic test_reset;
        idle_inputs;
        rst = 1;
        tick; tick;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL reset_order: got %b want 0", order); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (cnt_issued !== 32'd0) begin errors++; $display("FAIL reset_issued: got %0d want 0", cnt_issued); end
        checks++; if (cnt_killed !== 32'd0) begin errors++; $display("FAIL reset_killed: got %0d want 0", cnt_killed); end
        rst = 0;
        tick;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL post_reset_order: got %b want 0", order); end
    endtask

    task automatic test_in_order;
        int got = 0;
        drive_push(1, 0); drive_push(2, 0); drive_push(3, 0);
        accepted = 1; done = 1;
        for (int c = 0; c < 8; c++) begin
            if (order) begin
                checks++;
                if (got >= 3) begin errors++; $display("FAIL inorder_extra: got d_rs1=%0d want no issue", d_rs1); end
                else if (d_rs1 !== 32'(got + 1)) begin errors++; $display("FAIL inorder_data: got %0d want %0d", d_rs1, got + 1); end
                got++;
            end
            tick;
        end
        accepted = 0; done = 0; issued_exp += 3;
        checks++; if (got !== 3) begin errors++; $display("FAIL inorder_count: got %0d want 3", got); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inorder_ready: got %b want 1", in_ready); end
        checks++; if (cnt_issued !== exp_cnt(issued_exp)) begin errors++; $display("FAIL inorder_cnt: got %0d want %0d", cnt_issued, exp_cnt(issued_exp)); end
    endtask

    task automatic test_full;
        int got = 0;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'(10 + i), 0);
            checks++;
            if (in_ready !== (i < 3)) begin errors++; $display("FAIL full_ready%0d: got %b want %b", i, in_ready, i < 3); end
        end
        in_valid = 1; in_d_rs1 = 14;
        for (int c = 0; c < 2; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_block: got %b want 0", in_ready); end
            checks++; if (order !== 1'b1 || d_rs1 !== 32'd10) begin errors++; $display("FAIL full_head: got order=%b d=%0d want 1/10", order, d_rs1); end
            tick;
        end
        in_valid = 0;
        accepted = 1; done = 1;
        for (int c = 0; c < 10; c++) begin
            if (order) begin
                checks++;
                if (got >= 4) begin errors++; $display("FAIL full_extra: got d_rs1=%0d want no issue", d_rs1); end
                else if (d_rs1 !== 32'(10 + got)) begin errors++; $display("FAIL full_data: got %0d want %0d", d_rs1, 10 + got); end
                got++;
            end
            tick;
        end
        accepted = 0; done = 0; issued_exp += 4;
        checks++; if (got !== 4) begin errors++; $display("FAIL full_count: got %0d want 4", got); end
    endtask

    task automatic test_kill;
        int got = 0;
        drive_push(20, 0); drive_push(21, 1); drive_push(22, 0); drive_push(23, 1);
        kill = 1; kill_context = 1;
        tick;
        kill = 0;
        checks++; if (order !== 1'b1 || d_rs1 !== 32'd20) begin errors++; $display("FAIL kill_head: got order=%b d=%0d want 1/20", order, d_rs1); end
        accepted = 1; done = 1;
        for (int c = 0; c < 12; c++) begin
            if (order) begin
                checks++;
                if (got >= 2) begin errors++; $display("FAIL kill_extra: got d_rs1=%0d want no issue", d_rs1); end
                else if (d_rs1 !== (got == 0 ? 32'd20 : 32'd22)) begin errors++; $display("FAIL kill_data: got %0d want %0d", d_rs1, got == 0 ? 20 : 22); end
                got++;
            end
            tick;
        end
        accepted = 0; done = 0; issued_exp += 2; killed_exp += 2;
        checks++; if (got !== 2) begin errors++; $display("FAIL kill_count: got %0d want 2", got); end
        checks++; if (cnt_killed !== exp_cnt(killed_exp)) begin errors++; $display("FAIL kill_cnt: got %0d want %0d", cnt_killed, exp_cnt(killed_exp)); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_kill_push;
        in_valid = 1; in_d_rs1 = 40; in_context = 1; kill = 1; kill_context = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL killpush_ready: got %b want 1", in_ready); end
        tick;
        in_valid = 0; kill = 0; killed_exp += 1;
        tick; tick;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL killpush_stored: got order=%b want 0", order); end
        checks++; if (cnt_killed !== exp_cnt(killed_exp)) begin errors++; $display("FAIL killpush_cnt: got %0d want %0d", cnt_killed, exp_cnt(killed_exp)); end
    endtask

    task automatic test_wait;
        drive_push(30, 0); drive_push(31, 0);
        for (int c = 0; c < 5 && !order; c++) tick;
        checks++; if (order !== 1'b1 || d_rs1 !== 32'd30) begin errors++; $display("FAIL wait_first: got order=%b d=%0d want 1/30", order, d_rs1); end
        accepted = 1;
        tick;
        accepted = 0; issued_exp += 1;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL wait_n1: got %b want 0", order); end
        tick;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL wait_n2: got %b want 0", order); end
        tick;
        done = 1;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL wait_n3: got %b want 0", order); end
        tick;
        done = 0;
        checks++; if (order !== 1'b1 || d_rs1 !== 32'd31) begin errors++; $display("FAIL wait_n4: got order=%b d=%0d want 1/31", order, d_rs1); end
        accepted = 1; done = 1;
        tick;
        accepted = 0; done = 0; issued_exp += 1;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL wait_drain: got %b want 0", order); end
    endtask

    task automatic test_wrap;
        int pushed = 0;
        int popped = 0;
        for (int c = 0; c < 400 && popped < 12; c++) begin
            in_valid = (pushed < 12) && ($urandom_range(0, 3) != 0);
            in_d_rs1 = 32'(100 + pushed);
            accepted = 1'($urandom_range(0, 1));
            done = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) pushed++;
            if (order && accepted) begin
                checks++;
                if (d_rs1 !== 32'(100 + popped)) begin errors++; $display("FAIL wrap_data: got %0d want %0d", d_rs1, 100 + popped); end
                popped++;
            end
            tick;
        end
        in_valid = 0; accepted = 0; done = 1; issued_exp += 12;
        tick;
        done = 0;
        tick; tick;
        checks++; if (popped !== 12) begin errors++; $display("FAIL wrap_count: got %0d want 12", popped); end
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL wrap_empty: got order=%b want 0", order); end
        checks++; if (cnt_issued !== exp_cnt(issued_exp)) begin errors++; $display("FAIL wrap_cnt: got %0d want %0d", cnt_issued, exp_cnt(issued_exp)); end
    endtask

    task automatic test_reset_wait;
        drive_push(50, 0); drive_push(51, 0); drive_push(52, 0);
        for (int c = 0; c < 5 && !order; c++) tick;
        accepted = 1;
        tick;
        accepted = 0;
        #2;
        rst = 1;
        #1;
        issued_exp = 0; killed_exp = 0;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL rstwait_order: got %b want 0", order); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready: got %b want 1", in_ready); end
        checks++; if (cnt_issued !== 32'd0 || cnt_killed !== 32'd0) begin errors++; $display("FAIL rstwait_cnt: got %0d/%0d want 0/0", cnt_issued, cnt_killed); end
        tick;
        rst = 0; done = 1;
        tick;
        done = 0;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL rstwait_done1: got %b want 0", order); end
        tick;
        checks++; if (order !== 1'b0) begin errors++; $display("FAIL rstwait_done2: got %b want 0", order); end
        drive_push(60, 0);
        tick;
        checks++; if (order !== 1'b1 || d_rs1 !== 32'd60) begin errors++; $display("FAIL rstwait_new: got order=%b d=%0d want 1/60", order, d_rs1); end
        accepted = 1; done = 1;
        tick;
        accepted = 0; done = 0; issued_exp += 1;
        checks++; if (cnt_issued !== exp_cnt(issued_exp)) begin errors++; $display("FAIL rstwait_issued: got %0d want %0d", cnt_issued, exp_cnt(issued_exp)); end
    endtask

    initial begin
        test_reset;
        test_in_order;
        test_full;
        test_kill;
        test_kill_push;
        test_wait;
        test_wrap;
        test_reset_wait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_issue_queue.md
EXEC_ISSUE_QUEUE -- requirements
Module: exec_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have parameter LEN_CTX, default 2, meaning context-tag width.
REQ-003 SHALL have parameter LEN_PA, default 6, meaning physical-register address width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  upstream presents a decoded instruction.
REQ-007 SHALL have port in_ready  out  1  queue can take an entry this cycle.
REQ-008 SHALL have port in_exec_type  in  8  one-hot execution-unit select.
REQ-009 SHALL have port in_io_type / in_func3 / in_func7  in  1/3/7  opcode fields.
REQ-010 SHALL have port in_pa_rd  in  LEN_PA  destination physical register.
REQ-011 SHALL have port in_d_rs1 / in_d_rs2  in  32/32  operand values.
REQ-012 SHALL have port in_context / in_b_t_context / in_b_f_context  in  LEN_CTX each  context tags.
REQ-013 SHALL have port order  out  1  head entry offered to the exec stage.
REQ-014 SHALL have port accepted / done  in  1/1  exec-stage handshake.
REQ-015 SHALL have ports exec_type, io_type, func3, func7, pa_rd, d_rs1, d_rs2, context, b_t_context, b_f_context  out  same widths  head-entry payload.
REQ-016 SHALL have port kill  in  1  branch hazard strobe.
REQ-017 SHALL have port kill_context  in  LEN_CTX  context to squash.
REQ-018 SHALL have port cnt_issued / cnt_killed  out  32/32  statistics counters.

Function
REQ-019 SHALL store entries in a circular FIFO; head/tail pointers of log2(DEPTH) bits wrap DEPTH-1 -> 0; separate count of log2(DEPTH)+1 bits.
REQ-020 SHALL assert in_ready = (count < DEPTH), from registered state only; a push with count == DEPTH is not permitted even when a pop happens the same cycle.
REQ-021 SHALL write an entry on in_valid & in_ready at the rising edge, with per-entry kill flag cleared.
REQ-022 SHALL drive payload outputs combinationally from the head entry; with the queue empty the payload is don't-care and order is 0.
REQ-023 SHALL implement a 3-state FSM: IDLE, ISSUE, WAIT.
REQ-024 IDLE: order=0; -> ISSUE when the head is valid and not killed.
REQ-025 ISSUE: order=1, held until accepted; on accepted, pop head, increment cnt_issued; -> WAIT, or directly to ISSUE/IDLE (per next head) if done is also high that cycle.
REQ-026 WAIT: order=0; on done -> ISSUE if next head valid and not killed, else IDLE.
REQ-027 SHALL, on kill, set the kill flag of every valid entry whose context equals kill_context, in the same edge.
REQ-028 SHALL drop a killed head one entry per cycle in IDLE or ISSUE (no order asserted for it), incrementing cnt_killed; an entry already accepted is never affected.
REQ-029 SHALL discard, not store, an incoming push whose in_context equals kill_context while kill is high; in_ready is unaffected and cnt_killed increments.
REQ-030 SHALL allow simultaneous push and pop/drop in one cycle, count unchanged.
REQ-031 SHALL, if kill targets the head in ISSUE before accepted, deassert order the next cycle and drop it.
REQ-032 SHALL make statistics counters wrap 0xFFFFFFFF -> 0.

Reset
REQ-033 SHALL, while rst is high, force FSM=IDLE, head=tail=count=0, all kill flags 0, order=0, in_ready=1, cnt_issued=cnt_killed=0; reset mid-handshake discards all entries and any pending done is ignored after release.

Configuration
REQ-034 SHALL, with ISSUE_QUEUE_STATS_EN defined, implement cnt_issued/cnt_killed per REQ-025/028/029/032; without it, both outputs are constant 0 and no counter flops exist.

Verification
REQ-035 Reset, push 3 entries (d_rs1=1,2,3), accepted+done same cycle as each order -> issued in order 1,2,3, cnt_issued=3, count=0.
REQ-036 Push 4 with DEPTH=4, accepted held low -> in_ready=0 after fourth, fifth push blocked, order stays 1 with d_rs1 of entry 1.
REQ-037 Entries ctx 0,1,0,1 queued, kill with kill_context=1 -> only ctx-0 entries issued, cnt_killed=2.
REQ-038 accepted at cycle N, done at N+3 -> order low for N+1..N+3, next order at N+4.
REQ-039 Push 12 entries through DEPTH=4 with random stalls -> FIFO order preserved across pointer wrap.
REQ-040 rst asserted in WAIT with 2 entries queued -> order=0, in_ready=1, counters 0; done after release causes no transition.
